spi_slave_fl: RTL and testbench
===============================

# spi_slave_fl

SPI responder (flash-device side) for single-bit SPI mode 0. It decodes an 8-bit opcode, an optional 24-bit address, and either receives 32-bit write words on mosi or transmits 32-bit response words on miso. It sits opposite the flash SPI master as a flash/peripheral emulator. Its host side is a simple pulse/latency interface to a memory or register file. All SPI inputs are oversampled in the single system clock domain.

## Interface
- OP_READ, 8'h03: opcode, then address, then streamed tx words.
- OP_WRITE, 8'h02: opcode, then address, then streamed rx words.
- OP_RDID, 8'h9F: opcode, then streamed tx words; no address.
- RESP_LAT, 2: clk cycles from resp_req to tx_data capture (1..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from master, idle low.
- ss  in  1  slave select, active low.
- mosi  in  1  master-to-slave data, MSB first.
- miso  out  1  slave-to-master data, MSB first; driven 0 when not transmitting.
- cmd_out  out  8  last decoded opcode.
- addr_out  out  24  current word address.
- cmd_valid  out  1  one-cycle pulse when opcode (plus address, if any) is complete.
- rx_data  out  32  last received write word.
- rx_valid  out  1  one-cycle pulse per complete rx word.
- resp_req  out  1  one-cycle pulse requesting the next tx word for addr_out.
- tx_data  in  32  response word; captured RESP_LAT cycles after resp_req.
- busy  out  1  high from synchronized ss fall to synchronized ss rise.

## Operation
- **Synchronization:** sclk, ss and mosi pass through 2-FF synchronizers.
  - Rise/fall of sclk is detected on the synchronized signal against its 1-cycle-delayed copy.
  - mosi is sampled from its synchronized copy in the same cycle, so alignment is preserved.
  - The synchronized ss register resets to 1.
- **FSM states:** IDLE, CMD, ADDR, RX, TX.
- **IDLE:** on synchronized ss 1→0, go to CMD, set bit counter to 7, assert busy.
- **CMD:** shift mosi on each sclk rise. After the 8th bit, cmd_out <= opcode, then:
  - OP_READ or OP_WRITE → ADDR, counter 23.
  - OP_RDID → addr_out <= 0, pulse cmd_valid and resp_req, go to TX.
  - Any other opcode → pulse cmd_valid, go to IDLE-wait (ignore edges until ss rises).
- **ADDR:** shift 24 bits. After the last bit, addr_out <= address and pulse cmd_valid, then:
  - OP_READ → pulse resp_req, go to TX.
  - OP_WRITE → go to RX, counter 31.
- **RX:** shift 32 bits. After the 32nd bit:
  - rx_data <= word, pulse rx_valid; addr_out keeps the address of that word.
  - addr_out then increments by 4 in the following cycle (24-bit wrap, FFFFFC→000000).
  - Counter reloads to 31; the stream continues.
- **TX:** a shift register loads tx_data RESP_LAT cycles after resp_req.
  - On each sclk fall, miso <= shift[31] and the register shifts left.
  - The first fall after entering TX drives bit 31.
  - After the 32nd bit is driven, addr_out += 4 (wrap) and resp_req pulses for the next word; the stream continues.
- **ss rise (synchronized), any state:** return to IDLE, busy=0, miso=0, counter reset.
  - Partial opcode/address/rx words are discarded with no pulses.
  - A pending tx capture is cancelled.
- **Same-cycle ss rise and sclk edge:** ss wins; the edge is ignored.
- **Reset:** synchronized ss = 1 and FSM = IDLE. An ongoing transaction is ignored until ss is seen high then low again.

## Timing
- **Reset values:** miso 0, cmd_out 0, addr_out 0, cmd_valid 0, rx_data 0, rx_valid 0, resp_req 0, busy 0.
- **Input latency:** 3 clk from an sclk/ss pin edge to action (2 sync + 1 detect register).
- **Pulse timing:** cmd_valid, rx_valid and resp_req assert the cycle after the detected rise that completes the field.
- **miso update:** changes the cycle after a detected sclk fall, 4 clk after the pin edge.
- **Master constraints:**
  - sclk high and low phases each ≥ RESP_LAT + 5 clk cycles.
  - ss must fall ≥ 3 clk before the first sclk rise.
  - ss must rise ≥ 3 clk after the last sclk fall.
- **Host constraint:** tx_data must be stable in the capture cycle. Holding it from resp_req through capture is sufficient.

## Test plan
- **Command only:** opcode 8'h06, ss released → cmd_valid one pulse, cmd_out=06, no resp_req/rx_valid, busy drops 3 clk after ss rises.
- **READ streaming:**
  - Stimulus: 03, addr 0x00_10_00; host returns 0xDEADBEEF then 0x01234567; 64 sclk cycles.
  - Response: master samples DEADBEEF then 01234567 MSB first; resp_req pulses at addr 001000 and 001004.
- **WRITE streaming:** 02, addr 0xFFFFFC, data 0xA5A5A5A5, 0x5A5A5A5A → two rx_valid pulses with rx_data A5A5A5A5 at addr FFFFFC, then 5A5A5A5A at addr 000000.
- **RDID:** 9F then 32 clocks, host tx_data 0x00EF4018 → miso shows 00EF4018, addr_out=0, cmd_valid and resp_req in the same cycle.
- **Aborts:**
  - ss rises after 12 address bits → no cmd_valid.
  - ss rises after 20 WRITE data bits → no rx_valid.
  - In both cases the next transaction decodes normally.
- **Reset mid-transaction:** assert rst for 1 cycle mid-ADDR with ss held low and sclk running → all outputs at reset values, no pulses until ss cycles high→low; the following READ completes correctly.

Source files
------------

// File: rtl/spi_slave_fl_if.sv
// SPI responder bundle: SPI pins from the master plus host-side pulse/latency port.
// slave: DUT view (pins in, tx_data in; decode/host outputs out). master: bench view.
interface spi_slave_fl_if;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic [7:0]  cmd_out;
  logic [23:0] addr_out;
  logic        cmd_valid;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        resp_req;
  logic [31:0] tx_data;
  logic        busy;

  modport slave (
    input  sclk, ss, mosi, tx_data,
    output miso, cmd_out, addr_out, cmd_valid,
    output rx_data, rx_valid, resp_req, busy
  );

  modport master (
    output sclk, ss, mosi, tx_data,
    input  miso, cmd_out, addr_out, cmd_valid,
    input  rx_data, rx_valid, resp_req, busy
  );
endinterface

// File: rtl/spi_slave_fl.sv
// SPI mode-0 flash-side responder: opcode, optional 24-bit address, 32-bit rx/tx streams.
// Ports: clk, rst (sync, active high), bus (spi_slave_fl_if.slave: SPI pins + host port).
module spi_slave_fl #(
  parameter int RESP_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_fl_if.slave bus
);

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDID  = 8'h9F;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RX, S_TX, S_WAIT
  } state_t;

  state_t state;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;
  logic armed;

  logic [4:0]  cnt;
  logic [30:0] sreg;
  logic [31:0] tx_sh;
  logic [RESP_LAT-1:0] lat_pipe;
  logic        inc_pend;

  logic        miso_r;
  logic [7:0]  cmd_r;
  logic [23:0] addr_r;
  logic        cmd_valid_r;
  logic [31:0] rx_data_r;
  logic        rx_valid_r;
  logic        resp_req_r;
  logic        busy_r;

  logic        rise, fall, ss_fall, ss_rise;
  logic [31:0] word_w;

  // First stage is left unreset so it always tracks the pins,
  // which is what lets the arm flag see ss high after a reset.
  always_ff @(posedge clk) begin
    sclk_s1 <= bus.sclk;
    ss_s1   <= bus.ss;
    mosi_s1 <= bus.mosi;
    sclk_s2 <= sclk_s1;
    mosi_s2 <= mosi_s1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s2  <= 1'b1;
      ss_d   <= 1'b1;
      sclk_d <= 1'b0;
      armed  <= 1'b0;
    end else begin
      ss_s2  <= ss_s1;
      ss_d   <= ss_s2;
      sclk_d <= sclk_s2;
      armed  <= armed | ss_s1;
    end
  end

  assign rise    = sclk_s2 & ~sclk_d;
  assign fall    = ~sclk_s2 & sclk_d;
  // A fall only counts once ss has been seen high since reset.
  assign ss_fall = armed & ss_d & ~ss_s2;
  assign ss_rise = ss_s2 & ~ss_d;
  assign word_w  = {sreg, mosi_s2};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 5'd0;
      sreg        <= '0;
      tx_sh       <= '0;
      lat_pipe    <= '0;
      inc_pend    <= 1'b0;
      miso_r      <= 1'b0;
      cmd_r       <= 8'h00;
      addr_r      <= 24'h0;
      cmd_valid_r <= 1'b0;
      rx_data_r   <= 32'h0;
      rx_valid_r  <= 1'b0;
      resp_req_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      cmd_valid_r <= 1'b0;
      rx_valid_r  <= 1'b0;
      resp_req_r  <= 1'b0;
      inc_pend    <= 1'b0;
      lat_pipe    <= RESP_LAT'({lat_pipe, resp_req_r});
      if (inc_pend)
        addr_r <= addr_r + 24'd4;
      if (lat_pipe[RESP_LAT-1])
        tx_sh <= bus.tx_data;

      if (ss_rise) begin
        state    <= S_IDLE;
        busy_r   <= 1'b0;
        miso_r   <= 1'b0;
        cnt      <= 5'd0;
        lat_pipe <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (ss_fall) begin
              state  <= S_CMD;
              cnt    <= 5'd7;
              busy_r <= 1'b1;
            end
          end
          S_CMD: begin
            if (rise) begin
              sreg <= word_w[30:0];
              cnt  <= cnt - 5'd1;
              if (cnt == 5'd0) begin
                cmd_r <= word_w[7:0];
                if (word_w[7:0] == OP_READ ||
                    word_w[7:0] == OP_WRITE) begin
                  state <= S_ADDR;
                  cnt   <= 5'd23;
                end else if (word_w[7:0] == OP_RDID) begin
                  addr_r      <= 24'h0;
                  cmd_valid_r <= 1'b1;
                  resp_req_r  <= 1'b1;
                  state       <= S_TX;
                  cnt         <= 5'd31;
                end else begin
                  cmd_valid_r <= 1'b1;
                  state       <= S_WAIT;
                end
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              sreg <= word_w[30:0];
              cnt  <= cnt - 5'd1;
              if (cnt == 5'd0) begin
                addr_r      <= word_w[23:0];
                cmd_valid_r <= 1'b1;
                cnt         <= 5'd31;
                if (cmd_r == OP_READ) begin
                  resp_req_r <= 1'b1;
                  state      <= S_TX;
                end else begin
                  state <= S_RX;
                end
              end
            end
          end
          S_RX: begin
            if (rise) begin
              sreg <= word_w[30:0];
              cnt  <= cnt - 5'd1;
              if (cnt == 5'd0) begin
                rx_data_r  <= word_w;
                rx_valid_r <= 1'b1;
                inc_pend   <= 1'b1;
                cnt        <= 5'd31;
              end
            end
          end
          S_TX: begin
            if (fall) begin
              miso_r <= tx_sh[31];
              tx_sh  <= {tx_sh[30:0], 1'b0};
              cnt    <= cnt - 5'd1;
              if (cnt == 5'd0) begin
                addr_r     <= addr_r + 24'd4;
                resp_req_r <= 1'b1;
                cnt        <= 5'd31;
              end
            end
          end
          S_WAIT: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.miso      = miso_r;
  assign bus.cmd_out   = cmd_r;
  assign bus.addr_out  = addr_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.resp_req  = resp_req_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_spi_slave_fl.sv
// Bench for spi_slave_fl: table of SPI transactions plus abort and reset sequences.
// Acts as SPI master and as host (answers resp_req from a word queue).
module tb_spi_slave_fl;
  localparam int HP = 10;

  logic clk = 1'b0;
  logic rst;

  spi_slave_fl_if bus();

  spi_slave_fl #(.RESP_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  op;
    bit          has_addr;
    logic [23:0] addr;
    int          nw;
    bit          tx;
    logic [31:0] w0;
    logic [31:0] w1;
    int          e_cv;
    int          e_rr;
    int          e_rx;
    logic [23:0] ea0;
    logic [23:0] ea1;
  } vec_t;

  vec_t vecs [4];

  int n_cmp = 0;
  int n_bad = 0;

  int          cv_n;
  int          cv_rr;
  logic [23:0] rq_a [$];
  logic [31:0] rx_q [$];
  logic [23:0] rx_a [$];
  logic [31:0] tx_q [$];

  always @(negedge clk) begin
    if (bus.cmd_valid) begin
      cv_n++;
      if (bus.resp_req) cv_rr++;
    end
    if (bus.rx_valid) begin
      rx_q.push_back(bus.rx_data);
      rx_a.push_back(bus.addr_out);
    end
    if (bus.resp_req) begin
      rq_a.push_back(bus.addr_out);
      bus.tx_data = (tx_q.size() > 0) ? tx_q.pop_front() : 32'h0;
    end
  end

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    cv_n  = 0;
    cv_rr = 0;
    rq_a.delete();
    rx_q.delete();
    rx_a.delete();
    tx_q.delete();
  endtask

  task automatic xfer(input logic [31:0] d, input int n,
                      output logic [31:0] r);
    r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.mosi = d[i];
      clks(HP);
      r = {r[30:0], bus.miso};
      bus.sclk = 1'b1;
      clks(HP);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic spi_start();
    @(negedge clk);
    bus.ss = 1'b0;
    clks(5);
  endtask

  task automatic spi_stop(input string n, input bit chk_busy);
    clks(5);
    bus.ss = 1'b1;
    if (chk_busy) begin
      repeat (2) @(posedge clk);
      #1 chk({n, " busy_hold"}, 64'(bus.busy), 64'd1);
      @(posedge clk);
      #1 chk({n, " busy_drop"}, 64'(bus.busy), 64'd0);
      chk({n, " miso_idle"}, 64'(bus.miso), 64'd0);
    end
    clks(6);
  endtask

  task automatic rst_chk(input string n);
    chk({n, " miso"}, 64'(bus.miso), 64'd0);
    chk({n, " cmd_out"}, 64'(bus.cmd_out), 64'd0);
    chk({n, " addr_out"}, 64'(bus.addr_out), 64'd0);
    chk({n, " cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
    chk({n, " rx_data"}, 64'(bus.rx_data), 64'd0);
    chk({n, " rx_valid"}, 64'(bus.rx_valid), 64'd0);
    chk({n, " resp_req"}, 64'(bus.resp_req), 64'd0);
    chk({n, " busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] r;
    logic [31:0] got [2];
    logic [31:0] we;
    logic [23:0] ae;
    clear();
    if (v.tx) begin
      tx_q.push_back(v.w0);
      tx_q.push_back(v.w1);
    end
    spi_start();
    xfer({24'h0, v.op}, 8, r);
    if (v.has_addr) xfer({8'h0, v.addr}, 24, r);
    for (int i = 0; i < v.nw; i++) begin
      we = (i == 0) ? v.w0 : v.w1;
      xfer(v.tx ? 32'h0 : we, 32, r);
      got[i] = r;
    end
    spi_stop(v.name, 1'b1);
    chk({v.name, " cmd_valid_n"}, 64'(cv_n), 64'(v.e_cv));
    chk({v.name, " cmd_out"}, 64'(bus.cmd_out), 64'(v.op));
    chk({v.name, " resp_req_n"}, 64'(rq_a.size()), 64'(v.e_rr));
    chk({v.name, " rx_valid_n"}, 64'(rx_q.size()), 64'(v.e_rx));
    for (int i = 0; i < v.nw; i++) begin
      we = (i == 0) ? v.w0 : v.w1;
      ae = (i == 0) ? v.ea0 : v.ea1;
      if (v.tx) begin
        chk({v.name, " miso_word"}, 64'(got[i]), 64'(we));
      end else begin
        chk({v.name, " rx_data"},
            64'((rx_q.size() > i) ? rx_q[i] : 32'hBAD0BAD0), 64'(we));
        chk({v.name, " rx_addr"},
            64'((rx_a.size() > i) ? rx_a[i] : 24'hBADBAD), 64'(ae));
      end
    end
    if (v.tx) begin
      chk({v.name, " rq_addr0"},
          64'((rq_a.size() > 0) ? rq_a[0] : 24'hBADBAD), 64'(v.ea0));
      chk({v.name, " rq_addr1"},
          64'((rq_a.size() > 1) ? rq_a[1] : 24'hBADBAD), 64'(v.ea1));
    end
    if (v.op == 8'h9F) begin
      chk({v.name, " cv_with_rr"}, 64'(cv_rr), 64'd1);
      chk({v.name, " addr_zero"}, 64'(rq_a.size() > 0 ? rq_a[0] : 24'h1),
          64'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    bus.sclk    = 1'b0;
    bus.ss      = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 32'h0;
    rst         = 1'b1;
    clear();
    clks(4);
    rst = 1'b0;
    clks(4);
    rst_chk("por");

    vecs[0] = '{"cmd06", 8'h06, 1'b0, 24'h0, 0, 1'b0,
                32'h0, 32'h0, 1, 0, 0, 24'h0, 24'h0};
    // Third resp_req follows the 32nd fall of word 1 (addr 001008).
    vecs[1] = '{"read", 8'h03, 1'b1, 24'h001000, 2, 1'b1,
                32'hDEADBEEF, 32'h01234567, 1, 3, 0,
                24'h001000, 24'h001004};
    vecs[2] = '{"write", 8'h02, 1'b1, 24'hFFFFFC, 2, 1'b0,
                32'hA5A5A5A5, 32'h5A5A5A5A, 1, 0, 2,
                24'hFFFFFC, 24'h000000};
    vecs[3] = '{"rdid", 8'h9F, 1'b0, 24'h0, 1, 1'b1,
                32'h00EF4018, 32'h0, 1, 2, 0,
                24'h000000, 24'h000004};

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort mid-address: no cmd_valid.
    clear();
    spi_start();
    xfer(32'h03, 8, r);
    xfer(32'hABC, 12, r);
    spi_stop("abort_addr", 1'b1);
    chk("abort_addr cmd_valid_n", 64'(cv_n), 64'd0);
    chk("abort_addr resp_req_n", 64'(rq_a.size()), 64'd0);
    run_vec(vecs[1]);

    // Abort after 20 write data bits: address completes, no rx_valid.
    clear();
    spi_start();
    xfer(32'h02, 8, r);
    xfer(32'h000040, 24, r);
    xfer(32'hFFFFF, 20, r);
    spi_stop("abort_rx", 1'b1);
    chk("abort_rx cmd_valid_n", 64'(cv_n), 64'd1);
    chk("abort_rx rx_valid_n", 64'(rx_q.size()), 64'd0);
    run_vec(vecs[2]);

    // Reset mid-address with ss held low and sclk still toggling.
    clear();
    spi_start();
    xfer(32'h03, 8, r);
    xfer(32'h155, 10, r);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_chk("midrst");
    clear();
    xfer(32'h2AAA, 14, r);
    xfer(32'h03FFFFFF, 32, r);
    xfer(32'h9F, 8, r);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst miso", 64'(bus.miso), 64'd0);
    spi_stop("midrst", 1'b0);
    chk("midrst cmd_valid_n", 64'(cv_n), 64'd0);
    chk("midrst resp_req_n", 64'(rq_a.size()), 64'd0);
    chk("midrst rx_valid_n", 64'(rx_q.size()), 64'd0);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
